cpu_bus_bridge: RTL and testbench
=================================

CPU_BUS_BRIDGE -- requirements
Module: cpu_bus_bridge

Interface
REQ-001 The block SHALL have parameter address_width, default 32, meaning the width of the CPU and peripheral address buses.
REQ-002 The block SHALL have parameter PeriphBase, default 32'h0001_0000, meaning the base address of the peripheral window.
REQ-003 The block SHALL have parameter PeriphMask, default 32'hFFFF_0000, meaning the address bits compared against PeriphBase.
REQ-004 The block SHALL have parameter TimeoutCycles, default 255, range 2..65535, meaning the maximum WAIT cycles before forced completion.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port cpu_addr_i, input, address_width bits: CPU access address, valid only in the cycle cpu_addr_valid_i is high.
REQ-008 The block SHALL have port cpu_addr_valid_i, input, 1 bit: one-cycle strobe marking the start of a new CPU access.
REQ-009 The block SHALL have ports cpu_wdata_i (input, 32 bits, CPU write data) and cpu_wstrb_i (input, 4 bits, byte write strobes; 0 means read).
REQ-010 The block SHALL have port cpu_halt_o, output, 1 bit: stalls CPU mem_ready while high.
REQ-011 The block SHALL have port cpu_rdata_o, output, 32 bits: registered peripheral read data.
REQ-012 The block SHALL have ports periph_valid_o (output, 1), periph_addr_o (output, address_width), periph_wdata_o (output, 32) and periph_wstrb_o (output, 4).
REQ-013 The block SHALL have ports periph_rdata_i (input, 32) and periph_ready_i (input, 1, completes the peripheral access).
REQ-014 The block SHALL have port timeout_flag_o, output, 1 bit: sticky timeout indicator.

Function
REQ-015 The block SHALL implement the states IDLE and WAIT; cpu_halt_o and periph_valid_o SHALL be high exactly while the state is WAIT.
REQ-016 A strobe in IDLE with (cpu_addr_i & PeriphMask) == PeriphBase SHALL latch address, wdata and wstrb into periph_* and enter WAIT on the next cycle.
- With a strobe at cycle N, halt is high from N+1.
REQ-017 A strobe outside the peripheral window SHALL cause no state change, and cpu_halt_o SHALL stay low (zero-wait path).
REQ-018 periph_ready_i sampled high in WAIT at cycle M SHALL register periph_rdata_i into cpu_rdata_o and return the state to IDLE at M+1.
- cpu_halt_o is low at M+1.
REQ-019 periph_ready_i SHALL be ignored in IDLE; cpu_addr_valid_i SHALL be ignored in WAIT.
REQ-020 The periph_* outputs SHALL hold stable throughout WAIT.
- periph_wstrb_o SHALL clear to 0 on return to IDLE.
REQ-021 cpu_rdata_o SHALL hold its value until the next peripheral read completes.
- Write completions SHALL NOT update cpu_rdata_o.
REQ-022 The minimum peripheral access latency SHALL be 2 cycles from strobe to halt release (ready high on the first WAIT cycle).

Reset
REQ-023 reset_i high at a clock edge SHALL force state IDLE and drive all outputs low/zero on the next cycle, aborting any WAIT in progress.
- Outputs affected: cpu_halt_o, periph_valid_o, periph_addr_o, periph_wdata_o, periph_wstrb_o, cpu_rdata_o, timeout_flag_o.
- The WAIT counter SHALL be cleared.
REQ-024 A strobe coincident with reset_i SHALL be discarded.

Configuration
REQ-025 With macro BUS_TIMEOUT_EN defined, a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without ready.
- Timeout condition: the counter equals TimeoutCycles-1 with periph_ready_i still low.
- On timeout the block SHALL load cpu_rdata_o with 32'hDEAD_BEEF, set timeout_flag_o (sticky until reset) and return to IDLE.
- If ready and the timeout condition coincide, ready SHALL take priority and no flag is set.
REQ-026 Without BUS_TIMEOUT_EN, the block SHALL remain in WAIT indefinitely until ready, and timeout_flag_o SHALL be tied to 0.

Verification
REQ-027 Read strobe at addr 32'h0001_0004, ready with rdata 32'h1234_5678 on the 3rd WAIT cycle -> halt high for exactly 3 cycles, then cpu_rdata_o = 32'h1234_5678.
REQ-028 Write strobe at 32'h0001_0008, wstrb 4'b0011, wdata 32'hA5A5_0F0F -> periph_wstrb_o = 4'b0011 and wdata held through WAIT; cpu_rdata_o unchanged.
REQ-029 Strobe at 32'h0000_0100 -> halt and periph_valid_o never assert.
REQ-030 BUS_TIMEOUT_EN defined, TimeoutCycles = 4, ready never asserted -> halt high exactly 4 cycles, cpu_rdata_o = 32'hDEAD_BEEF, timeout_flag_o = 1 until reset.
REQ-031 reset_i pulsed on the 2nd WAIT cycle -> next cycle halt = 0, periph_valid_o = 0, all outputs zero; a later ready pulse has no effect.
REQ-032 Ready held high during IDLE, followed by a peripheral read strobe -> completion on the first WAIT cycle (2-cycle latency); no spurious completion occurs in IDLE.

Source files
------------

// File: rtl/cpu_bus_bridge.sv
// CPU-to-peripheral bus bridge: halts the CPU while a peripheral-window access is outstanding.
// Optional watchdog on the WAIT state is enabled by defining BUS_TIMEOUT_EN.
module cpu_bus_bridge #(
  parameter int unsigned                address_width = 32,
  parameter logic [address_width-1:0]   PeriphBase    = 32'h0001_0000,
  parameter logic [address_width-1:0]   PeriphMask    = 32'hFFFF_0000,
  parameter int unsigned                TimeoutCycles = 255
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] cpu_addr_i,
  input  logic                     cpu_addr_valid_i,
  input  logic [31:0]              cpu_wdata_i,
  input  logic [3:0]               cpu_wstrb_i,
  output logic                     cpu_halt_o,
  output logic [31:0]              cpu_rdata_o,
  output logic                     periph_valid_o,
  output logic [address_width-1:0] periph_addr_o,
  output logic [31:0]              periph_wdata_o,
  output logic [3:0]               periph_wstrb_o,
  input  logic [31:0]              periph_rdata_i,
  input  logic                     periph_ready_i,
  output logic                     timeout_flag_o,
  output logic                     state_dbg_o
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   window_hit;
  logic   accept;
  logic   complete;
  logic   timeout;

  // Handshake: periph_valid_o rises the cycle after an accepted strobe and stays high,
  // with addr/wdata/wstrb frozen, until periph_ready_i is sampled high at a clock edge.
  assign window_hit     = (cpu_addr_i & PeriphMask) == PeriphBase;
  assign accept         = (state_q == IDLE) && cpu_addr_valid_i && window_hit;
  assign complete       = (state_q == WAIT) && periph_ready_i;
  assign cpu_halt_o     = (state_q == WAIT);
  assign periph_valid_o = (state_q == WAIT);
  assign state_dbg_o    = state_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (complete || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);
  logic [15:0] wait_cnt_q;

  // Ready wins over a coincident expiry.
  assign timeout = (state_q == WAIT) && !periph_ready_i && (wait_cnt_q == TimeoutLast);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt_q     <= '0;
      timeout_flag_o <= 1'b0;
    end else begin
      if (state_q == IDLE)      wait_cnt_q <= '0;
      else if (!periph_ready_i) wait_cnt_q <= wait_cnt_q + 16'd1;
      if (timeout) timeout_flag_o <= 1'b1;
    end
  end
`else
  assign timeout        = 1'b0;
  assign timeout_flag_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      periph_addr_o  <= '0;
      periph_wdata_o <= '0;
      periph_wstrb_o <= '0;
      cpu_rdata_o    <= '0;
    end else if (accept) begin
      periph_addr_o  <= cpu_addr_i;
      periph_wdata_o <= cpu_wdata_i;
      periph_wstrb_o <= cpu_wstrb_i;
    end else if (complete) begin
      // A zero latched strobe marks the access as a read.
      if (periph_wstrb_o == 4'b0000) cpu_rdata_o <= periph_rdata_i;
      periph_wstrb_o <= '0;
    end else if (timeout) begin
      cpu_rdata_o    <= 32'hDEAD_BEEF;
      periph_wstrb_o <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge with hand-computed expectations; timeout case is
// exercised when BUS_TIMEOUT_EN is defined, otherwise the indefinite-wait behaviour is.
module tb_cpu_bus_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] cpu_addr_i = '0;
  logic        cpu_addr_valid_i = 1'b0;
  logic [31:0] cpu_wdata_i = '0;
  logic [3:0]  cpu_wstrb_i = '0;
  logic        cpu_halt_o;
  logic [31:0] cpu_rdata_o;
  logic        periph_valid_o;
  logic [31:0] periph_addr_o;
  logic [31:0] periph_wdata_o;
  logic [3:0]  periph_wstrb_o;
  logic [31:0] periph_rdata_i = '0;
  logic        periph_ready_i = 1'b0;
  logic        timeout_flag_o;
  logic        state_dbg_o;

  int checks = 0;
  int failures = 0;

  cpu_bus_bridge #(
    .address_width (32),
    .PeriphBase    (32'h0001_0000),
    .PeriphMask    (32'hFFFF_0000),
    .TimeoutCycles (4)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .cpu_addr_i       (cpu_addr_i),
    .cpu_addr_valid_i (cpu_addr_valid_i),
    .cpu_wdata_i      (cpu_wdata_i),
    .cpu_wstrb_i      (cpu_wstrb_i),
    .cpu_halt_o       (cpu_halt_o),
    .cpu_rdata_o      (cpu_rdata_o),
    .periph_valid_o   (periph_valid_o),
    .periph_addr_o    (periph_addr_o),
    .periph_wdata_o   (periph_wdata_o),
    .periph_wstrb_o   (periph_wstrb_o),
    .periph_rdata_i   (periph_rdata_i),
    .periph_ready_i   (periph_ready_i),
    .timeout_flag_o   (timeout_flag_o),
    .state_dbg_o      (state_dbg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_halt"},  {31'd0, cpu_halt_o},     32'd0);
    check({tag, "_valid"}, {31'd0, periph_valid_o}, 32'd0);
    check({tag, "_addr"},  periph_addr_o,           32'd0);
    check({tag, "_wdata"}, periph_wdata_o,          32'd0);
    check({tag, "_wstrb"}, {28'd0, periph_wstrb_o}, 32'd0);
    check({tag, "_rdata"}, cpu_rdata_o,             32'd0);
    check({tag, "_flag"},  {31'd0, timeout_flag_o}, 32'd0);
  endtask

  task automatic strobe(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    cpu_addr_i       = addr;
    cpu_wdata_i      = wdata;
    cpu_wstrb_i      = wstrb;
    cpu_addr_valid_i = 1'b1;
    tick();
    cpu_addr_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a coincident in-window strobe, which must be discarded
    reset_i          = 1'b1;
    cpu_addr_i       = 32'h0001_0000;
    cpu_addr_valid_i = 1'b1;
    tick();
    tick();
    reset_i          = 1'b0;
    cpu_addr_valid_i = 1'b0;
    check_idle_zero("reset");
    tick();
    check("reset_strobe_discard", {31'd0, cpu_halt_o}, 32'd0);

    // Read with ready on the 3rd WAIT cycle
    strobe(32'h0001_0004, 32'h0, 4'b0000);
    check("rd_w1_halt", {31'd0, cpu_halt_o}, 32'd1);
    check("rd_w1_valid", {31'd0, periph_valid_o}, 32'd1);
    check("rd_w1_addr", periph_addr_o, 32'h0001_0004);
    check("rd_w1_dbg", {31'd0, state_dbg_o}, 32'd1);
    tick();
    check("rd_w2_halt", {31'd0, cpu_halt_o}, 32'd1);
    tick();
    check("rd_w3_halt", {31'd0, cpu_halt_o}, 32'd1);
    periph_ready_i = 1'b1;
    periph_rdata_i = 32'h1234_5678;
    tick();
    periph_ready_i = 1'b0;
    periph_rdata_i = 32'h0;
    check("rd_done_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("rd_done_valid", {31'd0, periph_valid_o}, 32'd0);
    check("rd_done_rdata", cpu_rdata_o, 32'h1234_5678);

    // Write; a strobe during WAIT must be ignored and the write must not touch cpu_rdata_o
    strobe(32'h0001_0008, 32'hA5A5_0F0F, 4'b0011);
    check("wr_w1_wstrb", {28'd0, periph_wstrb_o}, 32'h3);
    check("wr_w1_wdata", periph_wdata_o, 32'hA5A5_0F0F);
    check("wr_w1_addr", periph_addr_o, 32'h0001_0008);
    cpu_addr_i       = 32'h0001_0020;
    cpu_wdata_i      = 32'h1111_2222;
    cpu_wstrb_i      = 4'b1111;
    cpu_addr_valid_i = 1'b1;
    tick();
    cpu_addr_valid_i = 1'b0;
    check("wr_w2_addr_hold", periph_addr_o, 32'h0001_0008);
    check("wr_w2_wdata_hold", periph_wdata_o, 32'hA5A5_0F0F);
    check("wr_w2_wstrb_hold", {28'd0, periph_wstrb_o}, 32'h3);
    check("wr_w2_halt", {31'd0, cpu_halt_o}, 32'd1);
    periph_ready_i = 1'b1;
    periph_rdata_i = 32'hFFFF_0000;
    tick();
    periph_ready_i = 1'b0;
    check("wr_done_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("wr_done_wstrb_clr", {28'd0, periph_wstrb_o}, 32'h0);
    check("wr_done_rdata_kept", cpu_rdata_o, 32'h1234_5678);
    tick();
    check("wr_no_restart", {31'd0, cpu_halt_o}, 32'd0);

    // Out-of-window strobe takes the zero-wait path
    strobe(32'h0000_0100, 32'h0, 4'b0000);
    check("oow_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("oow_valid", {31'd0, periph_valid_o}, 32'd0);
    tick();
    check("oow_halt2", {31'd0, cpu_halt_o}, 32'd0);
    check("oow_addr_kept", periph_addr_o, 32'h0001_0008);

    // Ready held in IDLE, then a read completes on the first WAIT cycle
    periph_ready_i = 1'b1;
    periph_rdata_i = 32'hCAFE_F00D;
    tick();
    tick();
    check("idle_rdy_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("idle_rdy_rdata", cpu_rdata_o, 32'h1234_5678);
    strobe(32'h0001_0010, 32'h0, 4'b0000);
    check("fast_w1_halt", {31'd0, cpu_halt_o}, 32'd1);
    tick();
    check("fast_done_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("fast_done_rdata", cpu_rdata_o, 32'hCAFE_F00D);
    periph_ready_i = 1'b0;
    periph_rdata_i = 32'h0;

    // Reset on the 2nd WAIT cycle aborts the access; a later ready does nothing
    strobe(32'h0001_0004, 32'h5555_AAAA, 4'b1000);
    check("abort_w1_halt", {31'd0, cpu_halt_o}, 32'd1);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_idle_zero("abort");
    periph_ready_i = 1'b1;
    periph_rdata_i = 32'h7777_7777;
    tick();
    periph_ready_i = 1'b0;
    tick();
    check("abort_late_rdy_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("abort_late_rdy_rdata", cpu_rdata_o, 32'h0);

    // Ready never arrives within TimeoutCycles = 4
    strobe(32'h0001_0004, 32'h0, 4'b0000);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_w%0d_halt", i), {31'd0, cpu_halt_o}, 32'd1);
      tick();
    end
`ifdef BUS_TIMEOUT_EN
    check("to_halt_released", {31'd0, cpu_halt_o}, 32'd0);
    check("to_rdata", cpu_rdata_o, 32'hDEAD_BEEF);
    check("to_flag", {31'd0, timeout_flag_o}, 32'd1);
    tick();
    tick();
    check("to_flag_sticky", {31'd0, timeout_flag_o}, 32'd1);
    // Ready on the expiry cycle wins: no flag
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("to_flag_reset", {31'd0, timeout_flag_o}, 32'd0);
    strobe(32'h0001_0004, 32'h0, 4'b0000);
    tick();
    tick();
    tick();
    periph_ready_i = 1'b1;
    periph_rdata_i = 32'h0BAD_F00D;
    tick();
    periph_ready_i = 1'b0;
    check("to_tie_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("to_tie_rdata", cpu_rdata_o, 32'h0BAD_F00D);
    check("to_tie_flag", {31'd0, timeout_flag_o}, 32'd0);
`else
    for (int i = 5; i <= 12; i++) begin
      check($sformatf("nto_w%0d_halt", i), {31'd0, cpu_halt_o}, 32'd1);
      tick();
    end
    check("nto_flag", {31'd0, timeout_flag_o}, 32'd0);
    periph_ready_i = 1'b1;
    periph_rdata_i = 32'h0BAD_F00D;
    tick();
    periph_ready_i = 1'b0;
    check("nto_done_halt", {31'd0, cpu_halt_o}, 32'd0);
    check("nto_done_rdata", cpu_rdata_o, 32'h0BAD_F00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
